// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg: shared constants and helpers for the dff_pipe elastic pipeline.
//   CLK_RISE / CLK_FALL : values for the CLK_EDGE parameter
//   occ_width(depth)    : bit width needed to count 0..depth valid stages
package dff_pipe_pkg;

   localparam int CLK_RISE = 1;
   localparam int CLK_FALL = 0;

   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// dff_pipe_stage: one valid+data register stage of the elastic pipeline.
// Ports:
//   clk      clock, active edge chosen by CLK_EDGE
//   clr      asynchronous active-high clear (valid=0, data=RESET_VAL)
//   en       clock enable; low holds all state
//   flush    synchronous flush (valid=0, data held) when en=1
//   load     stage may take new contents (downstream ready)
//   valid_i  incoming valid from previous stage / accept
//   data_i   incoming payload
//   valid_o  stage valid
//   data_o   stage payload
module dff_pipe_stage
   import dff_pipe_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               CLK_EDGE  = CLK_RISE,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             flush,
   input  logic             load,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;

   // Data only moves with a valid item so bubbles never overwrite payload.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (en) begin
         if (flush) begin
            valid_d = 1'b0;
         end else if (load) begin
            valid_d = valid_i;
            if (valid_i) begin
               data_d = data_i;
            end
         end
      end
   end

   generate
      if (CLK_EDGE == CLK_RISE) begin : g_rise
         always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
               valid_q <= 1'b0;
               data_q  <= RESET_VAL;
            end else begin
               valid_q <= valid_d;
               data_q  <= data_d;
            end
         end
      end else begin : g_fall
         always_ff @(negedge clk or posedge clr) begin
            if (clr) begin
               valid_q <= 1'b0;
               data_q  <= RESET_VAL;
            end else begin
               valid_q <= valid_d;
               data_q  <= data_d;
            end
         end
      end
   endgenerate

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit elastic register pipeline of DEPTH stages with
// valid/ready on both ends, bubble collapsing, clock enable, synchronous
// flush, async clear and selectable active clock edge.
// Ports:
//   clk, clr            clock (edge per CLK_EDGE) / async active-high clear
//   en, flush           clock enable / synchronous flush
//   in_valid, in_ready, in_data      upstream handshake and payload
//   out_valid, out_ready, out_data   downstream handshake and payload
//   occupancy           registered count of valid stages
module dff_pipe
   import dff_pipe_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 4,
   parameter int               CLK_EDGE  = CLK_RISE,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                          clk,
   input  logic                          clr,
   input  logic                          en,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_data,
   output logic [occ_width(DEPTH)-1:0]   occupancy
);

   localparam int OW = occ_width(DEPTH);

   logic [DEPTH-1:0] valid;
   logic [WIDTH-1:0] data [DEPTH];
   logic [DEPTH-1:0] vin;
   logic [WIDTH-1:0] din  [DEPTH];
   logic [DEPTH:0]   rdy;
   logic             accept, drain;
   logic [OW-1:0]    occ_q, occ_d;

   // Ready ripples from the output back to the input; a stage is free if it
   // is empty or the stage after it can move.
   always_comb begin
      rdy        = '0;
      rdy[DEPTH] = out_ready;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         rdy[DEPTH-1-k] = !valid[DEPTH-1-k] | rdy[DEPTH-k];
      end
   end

   assign in_ready  = en & ~flush & rdy[0];
   assign out_valid = en & ~flush & valid[DEPTH-1];
   assign out_data  = data[DEPTH-1];
   assign accept    = in_valid & in_ready;
   assign drain     = out_valid & out_ready;

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_stage
         if (i == 0) begin : g_head
            assign vin[i] = accept;
            assign din[i] = in_data;
         end else begin : g_body
            assign vin[i] = valid[i-1];
            assign din[i] = data[i-1];
         end

         dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .CLK_EDGE  (CLK_EDGE),
            .RESET_VAL (RESET_VAL)
         ) u_stage (
            .clk     (clk),
            .clr     (clr),
            .en      (en),
            .flush   (flush),
            .load    (rdy[i]),
            .valid_i (vin[i]),
            .data_i  (din[i]),
            .valid_o (valid[i]),
            .data_o  (data[i])
         );
      end
   endgenerate

   // accept/drain are already zero when en=0 or flush=1.
   always_comb begin
      occ_d = occ_q;
      if (en) begin
         if (flush) begin
            occ_d = '0;
         end else begin
            occ_d = occ_q + OW'(accept) - OW'(drain);
         end
      end
   end

   generate
      if (CLK_EDGE == CLK_RISE) begin : g_occ_rise
         always_ff @(posedge clk or posedge clr) begin
            if (clr) occ_q <= '0;
            else     occ_q <= occ_d;
         end
      end else begin : g_occ_fall
         always_ff @(negedge clk or posedge clr) begin
            if (clr) occ_q <= '0;
            else     occ_q <= occ_d;
         end
      end
   endgenerate

   assign occupancy = occ_q;

endmodule

// File: doc/dff_pipe.md
# dff_pipe

Parametrised elastic register pipeline: WIDTH-bit payload through DEPTH stages, valid/ready handshake on both ends, bubble collapsing, global clock enable, synchronous flush and selectable clock edge. It generalises the single-bit DFF family (edge polarity, async clear, enable) into the reusable multi-stage primitive used to retime data paths in QLF designs. It is also the flip-flop inference stress case for the plugin's DFF mapping and enable merging.

## Interface
Parameters:
- WIDTH, 8, payload width in bits (>=1)
- DEPTH, 4, number of register stages (>=1)
- CLK_EDGE, 1, active clock edge: 1 = rising, 0 = falling
- RESET_VAL, 0, WIDTH-bit value loaded into every stage data register on clr

Ports:
- clk  in  1  clock; active edge set by CLK_EDGE
- clr  in  1  reset clr, asynchronous, active-high; clock clk
- en  in  1  clock enable; low freezes all state
- flush  in  1  synchronous flush, active-high, sampled on active edge when en=1
- in_valid  in  1  upstream data valid
- in_ready  out  1  pipeline can accept in_data
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  stage DEPTH-1 holds valid data
- out_ready  in  1  downstream accepts out_data
- out_data  out  WIDTH  payload of stage DEPTH-1
- occupancy  out  $clog2(DEPTH+1)  number of valid stages, registered

## Operation
- Per stage i: valid_i, data_i. rdy_DEPTH = out_ready; rdy_i = !valid_i | rdy_(i+1), combinational chain.
- Stage i loads from stage i-1 (stage 0 from input) when rdy_i; valid_i <= valid_(i-1) (stage 0: in_valid & in_ready). data_i loads only when the incoming valid is 1, otherwise holds.
- in_ready = en & !flush & rdy_0. out_valid = en & !flush & valid_(DEPTH-1). out_data = data_(DEPTH-1) unmasked.
- Accept = in_valid & in_ready; drain = out_valid & out_ready. occupancy += accept - drain, saturation impossible by construction.
- en=0: no register changes, no handshakes (in_ready=0, out_valid=0). Order within pipe preserved.
- flush=1 with en=1: all valid_i <= 0, occupancy <= 0, data held; no accept, no drain that cycle.
- clr=1 (any time, async): valid_i=0, data_i=RESET_VAL, occupancy=0 immediately; mid-transfer data discarded. Deassertion synchronous to system; first accept possible at first active edge after release.
- Priority: clr > en=0 > flush > normal operation.
- Full (occupancy=DEPTH, out_ready=0): in_ready=0. Full with out_ready=1: simultaneous accept and drain, occupancy unchanged.
- in_valid may not depend on in_ready; out_ready may depend on out_valid.

## Timing
- Reset values: in_ready=en&!flush (rdy_0=1), out_valid=0, out_data=RESET_VAL, occupancy=0.
- Latency: item accepted at edge k into empty pipe shows out_valid after edge k+DEPTH-1 (DEPTH cycles incl. accept edge).
- Throughput: 1 item/cycle sustained with out_ready=1.
- Bubbles collapse: a stalled output lets upstream stages fill until all DEPTH stages valid.
- Combinational paths: out_ready -> in_ready through DEPTH stages; no input-to-output data path.
- CLK_EDGE=0: all above referenced to falling edge; clr behaviour unchanged.

## Structure
- Package dff_pipe_pkg: CLK_RISE=1/CLK_FALL=0 constants, occ_width(depth) function.
- Sub-module dff_pipe_stage: one valid+data stage with load, flush, en, async clr and RESET_VAL, edge selected by CLK_EDGE generate; top instantiates DEPTH copies plus ready chain and occupancy counter.

## Test plan
- Reset: clr pulse mid-stream with RESET_VAL=8'hA5 -> out_valid=0, out_data=8'hA5, occupancy=0 without clock edge.
- Streaming: DEPTH=4, feed 0x01..0x10 with out_ready=1 -> first out_valid 4 cycles after first accept, then one item per cycle in order, occupancy steady 4.
- Backpressure: out_ready=0, feed 6 items -> occupancy 4, in_ready=0 after 4th; release out_ready -> items 1..6 in order, no loss/dup.
- Bubbles: in_valid toggling 1/0, out_ready=0 -> stages compact, occupancy equals accepted count.
- Flush/enable: en=0 for 3 cycles with full pipe -> state and occupancy frozen, no handshakes; flush=1 -> occupancy 0, out_valid 0 next cycle.
- CLK_EDGE=0, DEPTH=1, WIDTH=1 -> transfers only on falling edges, latency 1 cycle.
